// File: rtl/coffee_vend_pkg.sv
// Shared types, coin constants and the product price table for the coffee vending controller.
package coffee_vend_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3,
    REFUND   = 3'd4
  } vend_state_e;

  localparam logic [3:0] COIN_1  = 4'd1;
  localparam logic [3:0] COIN_2  = 4'd2;
  localparam logic [3:0] COIN_5  = 4'd5;
  localparam logic [3:0] COIN_10 = 4'd10;

  localparam int PRICE_W    = 8;
  localparam int NUM_PRICED = 4;
  // filter, black, bru, nescafe
  localparam logic [PRICE_W-1:0] PRICE [NUM_PRICED] = '{8'd2, 8'd1, 8'd5, 8'd10};
  localparam logic [PRICE_W-1:0] PRICE_DEFAULT = 8'd10;

  function automatic logic [PRICE_W-1:0] price_of(input int unsigned idx);
    logic [PRICE_W-1:0] p;
    if (idx < NUM_PRICED) begin
      p = PRICE[idx[1:0]];
    end else begin
      p = PRICE_DEFAULT;
    end
    return p;
  endfunction

  function automatic logic coin_legal(input logic [3:0] v);
    return (v == COIN_1) || (v == COIN_2) || (v == COIN_5) || (v == COIN_10);
  endfunction

endpackage

// File: rtl/coffee_coin_validator.sv
// Combinational coin check: legal denomination, no credit overflow, and not blocked by controller state.
module coffee_coin_validator
  import coffee_vend_pkg::*;
#(
  parameter int SUM_W   = 6,
  parameter int MAX_SUM = 31
)(
  input  logic             coin_valid,
  input  logic [3:0]       coin_val,
  input  logic [SUM_W-1:0] credit,
  input  logic             block,
  output logic             accept,
  output logic             reject,
  output logic [SUM_W-1:0] sum
);

  localparam logic [SUM_W:0] MAX_WIDE = (SUM_W+1)'(MAX_SUM);

  logic [SUM_W:0] sum_wide_s;
  logic           over_s;

  // One extra bit on the sum so an overflowing coin never wraps into a small credit
  always_comb begin
    sum_wide_s = (SUM_W+1)'(credit) + (SUM_W+1)'(coin_val);
    over_s     = (sum_wide_s > MAX_WIDE);
    accept     = coin_valid && coin_legal(coin_val) && !over_s && !block;
    reject     = coin_valid && !accept;
    sum        = sum_wide_s[SUM_W-1:0];
  end

endmodule

// File: rtl/coffee_vend_ctrl.sv
// Coin-summing coffee vending controller: credit, selection, timed dispense, change and refund.
// Optional idle-credit timeout refund is built when COFFEE_TIMEOUT_EN is defined.
module coffee_vend_ctrl
  import coffee_vend_pkg::*;
#(
  parameter int NUM_PRODUCTS    = 4,
  parameter int SUM_W           = 6,
  parameter int MAX_SUM         = 31,
  parameter int DISPENSE_CYCLES = 4,
`ifdef COFFEE_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES  = 1024,
`endif
  localparam int SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_valid,
  input  logic [3:0]       coin_val,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel_id,
  input  logic             cancel,
  output logic             coin_reject,
  output logic             dispense,
  output logic [SEL_W-1:0] dispense_id,
  output logic             change_valid,
  output logic [SUM_W-1:0] change_amt,
  output logic [SUM_W-1:0] credit,
  output logic             led_green,
  output logic             led_yellow
);

  localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISPENSE_CYCLES - 1);
  localparam int CMP_W = (SUM_W > PRICE_W) ? SUM_W : PRICE_W;

  vend_state_e      state_r, state_next_s;
  logic [SUM_W-1:0] credit_r, credit_next_s, coin_sum_s, change_next_s;
  logic [SEL_W-1:0] sel_r, sel_next_s;
  logic             sel_vld_r, sel_vld_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             coin_block_s, coin_accept_s, coin_reject_s;
  logic             sel_ok_s, sel_take_s, vend_ready_s, tmo_hit_s;
  logic [CMP_W-1:0] credit_ext_s, price_ext_s;

  assign credit_ext_s = CMP_W'(credit_r);
  assign price_ext_s  = CMP_W'(price_of(32'(sel_r)));
  assign vend_ready_s = sel_vld_r && (credit_ext_s >= price_ext_s);
  assign sel_ok_s     = sel_valid && (int'(sel_id) < NUM_PRODUCTS);
  // A pending cancel or timeout in COLLECT outranks a coin arriving in the same cycle
  assign coin_block_s = !((state_r == IDLE) ||
                          ((state_r == COLLECT) && !cancel && !tmo_hit_s));
  assign sel_take_s   = sel_ok_s && ((state_r == IDLE) ||
                        ((state_r == COLLECT) && !cancel && !tmo_hit_s && !vend_ready_s));
  assign credit       = credit_r;

  coffee_coin_validator #(
    .SUM_W   (SUM_W),
    .MAX_SUM (MAX_SUM)
  ) u_coin_validator (
    .coin_valid (coin_valid),
    .coin_val   (coin_val),
    .credit     (credit_r),
    .block      (coin_block_s),
    .accept     (coin_accept_s),
    .reject     (coin_reject_s),
    .sum        (coin_sum_s)
  );

`ifdef COFFEE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt_r;

  // Idle-credit counter, restarted by any customer activity while collecting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if ((state_r != COLLECT) || coin_accept_s || sel_ok_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 1'b1;
    end
  end

  assign tmo_hit_s = (state_r == COLLECT) && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state, credit and selection logic
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    if (coin_accept_s) begin
      credit_next_s = coin_sum_s;
    end else begin
      credit_next_s = credit_r;
    end
    if (sel_take_s) begin
      sel_next_s     = sel_id;
      sel_vld_next_s = 1'b1;
    end else begin
      sel_next_s     = sel_r;
      sel_vld_next_s = sel_vld_r;
    end
    case (state_r)
      IDLE: begin
        if (coin_accept_s) begin
          state_next_s = COLLECT;
        end else begin
          state_next_s = IDLE;
        end
      end
      COLLECT: begin
        if (cancel || tmo_hit_s) begin
          state_next_s = REFUND;
        end else if (vend_ready_s) begin
          state_next_s = DISPENSE;
          cnt_next_s   = '0;
        end else begin
          state_next_s = COLLECT;
        end
      end
      DISPENSE: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = CHANGE;
        end else begin
          cnt_next_s = cnt_r + 1'b1;
        end
      end
      CHANGE, REFUND: begin
        state_next_s   = IDLE;
        credit_next_s  = '0;
        sel_next_s     = '0;
        sel_vld_next_s = 1'b0;
      end
      default: begin
        state_next_s   = IDLE;
        credit_next_s  = '0;
        sel_next_s     = '0;
        sel_vld_next_s = 1'b0;
      end
    endcase
  end

  // Change owed on the cycle the vend or refund completes
  always_comb begin
    if (state_next_s == CHANGE) begin
      change_next_s = SUM_W'(credit_ext_s - price_ext_s);
    end else if (state_next_s == REFUND) begin
      change_next_s = credit_r;
    end else begin
      change_next_s = '0;
    end
  end

  // Controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      credit_r  <= '0;
      sel_r     <= '0;
      sel_vld_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_next_s;
      credit_r  <= credit_next_s;
      sel_r     <= sel_next_s;
      sel_vld_r <= sel_vld_next_s;
      cnt_r     <= cnt_next_s;
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coin_reject  <= 1'b0;
      dispense     <= 1'b0;
      dispense_id  <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      led_green    <= 1'b1;
      led_yellow   <= 1'b0;
    end else begin
      coin_reject  <= coin_reject_s;
      dispense     <= (state_next_s == DISPENSE);
      dispense_id  <= (state_next_s == DISPENSE) ? sel_next_s : '0;
      change_valid <= (state_next_s == CHANGE) || (state_next_s == REFUND);
      change_amt   <= change_next_s;
      led_green    <= (state_next_s == IDLE) && (credit_next_s == '0);
      led_yellow   <= (state_next_s == DISPENSE) || (state_next_s == CHANGE);
    end
  end

endmodule

// File: tb/tb_coffee_vend_ctrl.sv
// Self-checking bench for coffee_vend_ctrl: transaction-level reference model plus directed scenarios.
module tb_coffee_vend_ctrl;

  localparam int NP   = 4;
  localparam int SW   = 6;
  localparam int MAXS = 31;
  localparam int DC   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          coin_valid = 1'b0;
  logic [3:0]    coin_val = 4'd0;
  logic          sel_valid = 1'b0;
  logic [1:0]    sel_id = 2'd0;
  logic          cancel = 1'b0;
  logic          coin_reject, dispense, change_valid, led_green, led_yellow;
  logic [1:0]    dispense_id;
  logic [SW-1:0] change_amt, credit;

  coffee_vend_ctrl #(
    .NUM_PRODUCTS    (NP),
    .SUM_W           (SW),
    .MAX_SUM         (MAXS),
    .DISPENSE_CYCLES (DC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .coin_reject  (coin_reject),
    .dispense     (dispense),
    .dispense_id  (dispense_id),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .credit       (credit),
    .led_green    (led_green),
    .led_yellow   (led_yellow)
  );

  always #5 clk = ~clk;

  // Reference model: credit/selection bookkeeping plus a schedule of the busy cycles of a vend
  typedef struct packed {
    logic       disp;
    logic [1:0] id;
    logic       cv;
    logic [5:0] amt;
    logic       yellow;
    logic [5:0] cr;
  } exp_t;

  exp_t       sched_q[$];
  int         m_credit = 0;
  int         m_sel = -1;
  int         price_tab [4] = '{2, 1, 5, 10};
  logic       e_reject = 1'b0, e_disp = 1'b0, e_cv = 1'b0, e_green = 1'b1, e_yellow = 1'b0;
  logic [1:0] e_id = 2'd0;
  logic [5:0] e_amt = 6'd0, e_cr = 6'd0;

  always @(posedge clk or posedge rst) begin : model
    exp_t cur;
    logic busy_prev;
    logic vend;
    if (rst) begin
      sched_q.delete();
      m_credit = 0; m_sel = -1;
      e_reject = 1'b0; e_disp = 1'b0; e_id = 2'd0; e_cv = 1'b0;
      e_amt = 6'd0; e_cr = 6'd0; e_green = 1'b1; e_yellow = 1'b0;
    end else begin
      busy_prev = e_disp || e_cv;
      e_reject = 1'b0;
      if (busy_prev) begin
        e_reject = coin_valid;
        if (sched_q.size() > 0) begin
          cur = sched_q.pop_front();
          e_disp = cur.disp; e_id = cur.id; e_cv = cur.cv; e_amt = cur.amt;
          e_yellow = cur.yellow; e_cr = cur.cr; e_green = 1'b0;
        end else begin
          e_disp = 1'b0; e_id = 2'd0; e_cv = 1'b0; e_amt = 6'd0;
          e_yellow = 1'b0; e_cr = 6'd0; e_green = 1'b1;
        end
      end else if (cancel && (m_credit > 0)) begin
        e_reject = coin_valid;
        e_disp = 1'b0; e_id = 2'd0; e_cv = 1'b1; e_amt = 6'(m_credit);
        e_yellow = 1'b0; e_cr = 6'(m_credit); e_green = 1'b0;
        m_credit = 0; m_sel = -1;
      end else begin
        vend = (m_credit > 0) && (m_sel >= 0) && (m_credit >= price_tab[m_sel[1:0]]);
        if (coin_valid) begin
          if ((coin_val inside {4'd1, 4'd2, 4'd5, 4'd10}) && (m_credit + int'(coin_val) <= MAXS))
            m_credit = m_credit + int'(coin_val);
          else
            e_reject = 1'b1;
        end
        if (vend) begin
          for (int k = 1; k < DC; k++)
            sched_q.push_back('{disp: 1'b1, id: 2'(m_sel), cv: 1'b0, amt: 6'd0,
                                yellow: 1'b1, cr: 6'(m_credit)});
          sched_q.push_back('{disp: 1'b0, id: 2'd0, cv: 1'b1,
                              amt: 6'(m_credit - price_tab[m_sel[1:0]]),
                              yellow: 1'b1, cr: 6'(m_credit)});
          e_disp = 1'b1; e_id = 2'(m_sel); e_cv = 1'b0; e_amt = 6'd0;
          e_yellow = 1'b1; e_cr = 6'(m_credit); e_green = 1'b0;
          m_credit = 0; m_sel = -1;
        end else begin
          if (sel_valid) m_sel = int'(sel_id);
          e_disp = 1'b0; e_id = 2'd0; e_cv = 1'b0; e_amt = 6'd0;
          e_yellow = 1'b0; e_cr = 6'(m_credit); e_green = (m_credit == 0);
        end
      end
    end
  end

  int    n_checks = 0, n_fail = 0;
  int    n_change = 0, n_disp = 0, n_rej = 0;
  int    last_amt = -1, last_id = -1;
  string req_nm = "";
  int    req_act = 0, req_exp = 0, req_seq = 0, done_seq = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Single compare process: every output every cycle, event monitor, and queued literal checks
  always @(negedge clk) begin
    chk("coin_reject",  int'(coin_reject),  int'(e_reject));
    chk("dispense",     int'(dispense),     int'(e_disp));
    chk("dispense_id",  int'(dispense_id),  int'(e_id));
    chk("change_valid", int'(change_valid), int'(e_cv));
    chk("change_amt",   int'(change_amt),   int'(e_amt));
    chk("credit",       int'(credit),       int'(e_cr));
    chk("led_green",    int'(led_green),    int'(e_green));
    chk("led_yellow",   int'(led_yellow),   int'(e_yellow));
    if (change_valid) begin n_change++; last_amt = int'(change_amt); end
    if (dispense) begin n_disp++; last_id = int'(dispense_id); end
    if (coin_reject) n_rej++;
    if (req_seq != done_seq) begin
      chk(req_nm, req_act, req_exp);
      done_seq = req_seq;
    end
  end

  task automatic pulse(input logic cv, input logic [3:0] v, input logic sv,
                       input logic [1:0] sid, input logic cn);
    coin_valid = cv; coin_val = v; sel_valid = sv; sel_id = sid; cancel = cn;
    @(negedge clk);
    coin_valid = 1'b0; coin_val = 4'd0; sel_valid = 1'b0; sel_id = 2'd0; cancel = 1'b0;
  endtask

  task automatic coin(input logic [3:0] v); pulse(1'b1, v, 1'b0, 2'd0, 1'b0); endtask
  task automatic sel(input logic [1:0] s); pulse(1'b0, 4'd0, 1'b1, s, 1'b0); endtask
  task automatic ticks(input int n); repeat (n) @(negedge clk); endtask

  task automatic lit(input string nm, input int act, input int exp);
    req_nm = nm; req_act = act; req_exp = exp; req_seq++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int c0, d0, r0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    lit("reset_green", int'(led_green), 1);
    lit("reset_credit", int'(credit), 0);
    lit("reset_dispense", int'(dispense), 0);
    rst = 1'b0;
    ticks(1);

    // black (price 1), one rupee: exact change
    c0 = n_change; d0 = n_disp;
    sel(2'd1); coin(4'd1); ticks(8);
    lit("s1_disp_cycles", n_disp - d0, 4);
    lit("s1_disp_id", last_id, 1);
    lit("s1_change_cnt", n_change - c0, 1);
    lit("s1_change_amt", last_amt, 0);
    lit("s1_green", int'(led_green), 1);

    // bru (price 5), three 2-rupee coins
    c0 = n_change;
    sel(2'd2); coin(4'd2); coin(4'd2);
    lit("s2_credit4", int'(credit), 4);
    coin(4'd2); ticks(8);
    lit("s2_change_amt", last_amt, 1);
    lit("s2_disp_id", last_id, 2);
    lit("s2_change_cnt", n_change - c0, 1);

    // 5 + 10 then cancel: full refund, nothing dispensed
    c0 = n_change; d0 = n_disp;
    coin(4'd5); coin(4'd10); pulse(1'b0, 4'd0, 1'b0, 2'd0, 1'b1); ticks(2);
    lit("s3_refund_amt", last_amt, 15);
    lit("s3_refund_cnt", n_change - c0, 1);
    lit("s3_no_dispense", n_disp - d0, 0);

    // overflow and illegal coin rejection at credit 30
    coin(4'd10); coin(4'd10); coin(4'd10);
    lit("s4_credit30", int'(credit), 30);
    r0 = n_rej;
    coin(4'd2); coin(4'd3); ticks(1);
    lit("s4_credit_held", int'(credit), 30);
    lit("s4_reject_cnt", n_rej - r0, 2);
    pulse(1'b0, 4'd0, 1'b0, 2'd0, 1'b1); ticks(2);
    lit("s4_refund_amt", last_amt, 30);

    // coin inserted while dispensing nescafe
    r0 = n_rej;
    sel(2'd3); coin(4'd10); ticks(1); coin(4'd5); ticks(8);
    lit("s5_reject_cnt", n_rej - r0, 1);
    lit("s5_disp_id", last_id, 3);
    lit("s5_change_amt", last_amt, 0);

    // coin and cancel together: cancel wins, coin returned
    r0 = n_rej; c0 = n_change;
    coin(4'd5); pulse(1'b1, 4'd2, 1'b0, 2'd0, 1'b1); ticks(2);
    lit("s6_refund_amt", last_amt, 5);
    lit("s6_reject_cnt", n_rej - r0, 1);
    lit("s6_credit", int'(credit), 0);

    // coin and selection in the same cycle
    c0 = n_change;
    pulse(1'b1, 4'd2, 1'b1, 2'd0, 1'b0); ticks(8);
    lit("s7_disp_id", last_id, 0);
    lit("s7_change_amt", last_amt, 0);
    lit("s7_change_cnt", n_change - c0, 1);

    // reset in the middle of a dispense
    sel(2'd1); coin(4'd2); ticks(2);
    lit("s8_pre_dispense", int'(dispense), 1);
    #1 rst = 1'b1;
    #1;
    lit("s8_rst_dispense", int'(dispense), 0);
    lit("s8_rst_green", int'(led_green), 1);
    lit("s8_rst_credit", int'(credit), 0);
    lit("s8_rst_yellow", int'(led_yellow), 0);
    rst = 1'b0;
    ticks(3);
    lit("s8_idle_green", int'(led_green), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coffee_vend_ctrl.md
Name: coffee_vend_ctrl

Overview:
Parametrised vending controller, the successor to the single-register coin summing FSM. Accepts coins as valued strobes and latches a product selection. Compares the running credit against a per-product price table, drives the dispenser for a fixed pulse width, then returns change. Supports cancel/refund and credit-overflow rejection. Sits between the coin acceptor/keypad front end and the dispenser/LED/change-hopper drivers.

Parameters:
NUM_PRODUCTS, 4, number of selectable products (index width SEL_W = $clog2(NUM_PRODUCTS), minimum 1)
SUM_W, 6, width of the credit register and of change_amt
MAX_SUM, 31, highest credit accepted; must be <= 2**SUM_W-1
DISPENSE_CYCLES, 4, cycles dispense stays high per vend (>=1)
TIMEOUT_CYCLES, 1024, idle-credit timeout (used only by the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
coin_valid  in  1  one-cycle strobe, coin inserted
coin_val  in  4  coin value in rupees (1, 2, 5 or 10; other values rejected)
sel_valid  in  1  one-cycle strobe, product chosen
sel_id  in  SEL_W  product index
cancel  in  1  one-cycle strobe, refund request
coin_reject  out  1  one-cycle pulse, coin not credited (return to user)
dispense  out  1  dispenser drive
dispense_id  out  SEL_W  product being dispensed, valid while dispense=1
change_valid  out  1  one-cycle pulse, change_amt valid
change_amt  out  SUM_W  rupees to return
credit  out  SUM_W  current credit (display)
led_green  out  1  machine idle and ready
led_yellow  out  1  vend in progress (DISPENSE or CHANGE)

Behaviour:
- Reset (async, rst=1): state=IDLE, credit=0, selection cleared. All outputs 0 except led_green=1.
- States: IDLE, COLLECT, DISPENSE, CHANGE, REFUND.
- IDLE: accepted coin -> credit=coin_val, go COLLECT. sel_valid with sel_id<NUM_PRODUCTS latches selection and stays in IDLE. cancel is ignored.
- COLLECT: accepted coin -> credit += coin_val. sel_valid latches or overwrites the selection. cancel -> REFUND.
- Vend check uses registered credit and selection: selection latched and credit >= PRICE[sel] -> DISPENSE on the next edge. Latency is one cycle from the credit or selection update to dispense=1.
- DISPENSE: dispense=1 and dispense_id=sel for exactly DISPENSE_CYCLES cycles, then CHANGE.
- CHANGE: one cycle. change_valid=1, change_amt=credit-PRICE[sel] (0 allowed, still pulsed). credit and selection cleared. Go IDLE.
- REFUND: one cycle. change_valid=1, change_amt=credit. Clear credit and selection. Go IDLE.
- Coin rejection, with a coin_reject pulse the following cycle and credit unchanged, when any of these holds:
  - coin_val is not in {1,2,5,10};
  - credit+coin_val > MAX_SUM (computed at SUM_W+1 bits, no wrap);
  - state is DISPENSE, CHANGE or REFUND.
- sel_valid with sel_id >= NUM_PRODUCTS is ignored. sel_valid outside IDLE/COLLECT is ignored.
- Simultaneous events:
  - coin+cancel in COLLECT: cancel wins and the coin is rejected.
  - coin+sel: both applied in the same cycle.
  - sel change while credit already covers the old price: irrelevant, because the check fires the cycle after the old selection met its price.
- credit output mirrors the internal register. led_green=1 only in IDLE with credit=0. led_yellow=1 in DISPENSE and CHANGE.
- rst asserted mid-vend aborts immediately. No change is issued and credit is lost; this is accepted behaviour.

Optional Feature:
COFFEE_TIMEOUT_EN. When defined, a counter runs in COLLECT and restarts on any accepted coin or sel_valid. Reaching TIMEOUT_CYCLES-1 forces REFUND, identical to cancel. When undefined, there is no counter or timeout logic and COLLECT waits indefinitely.

Decomposition:
Package coffee_vend_pkg holds:
- state enum vend_state_e;
- coin value constants COIN_1/2/5/10;
- PRICE table as localparam array, indexed by product: filter 2, black 1, bru 5, nescafe 10; products beyond index 3 default to 10.
One sub-module, coffee_coin_validator, is natural: combinational legality and overflow check producing accept/reject.

Test Plan:
- sel_id=1 (black, 1), coin 1 -> dispense high 4 cycles with dispense_id=1, then change_valid with change_amt=0, led_green back to 1.
- sel_id=2 (bru, 5), coins 2,2,2 -> dispense after third coin credit=6, then change_amt=1.
- coins 5,10, cancel -> change_valid with change_amt=15 one cycle after cancel; no dispense.
- credit 30, coin 2 -> coin_reject pulse, credit stays 30. coin_val=3 -> coin_reject, credit unchanged.
- coin during DISPENSE -> coin_reject; coin+cancel same cycle in COLLECT with credit 5 -> reject, refund 5. rst mid-DISPENSE -> all outputs 0, led_green=1 immediately.
- With COFFEE_TIMEOUT_EN and TIMEOUT_CYCLES=16: coin 2 then idle 16 cycles -> change_valid with change_amt=2.
